downstream_cxl_accumulator: RTL and testbench



---
 rtl/downstream_pkg.sv | 24 ++
 rtl/downstream_acc_ram.sv | 44 ++++
 rtl/downstream_cxl_accumulator.sv | 168 ++++++++++++++++
 tb/tb_downstream_cxl_accumulator.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/downstream_pkg.sv
// downstream_pkg: shared types and constants for the downstream cancelled-order
// accumulator. Widths here are the default build (32 clients, 16-bit amounts,
// 24-bit totals); the modules take their own parameters and derive widths from
// them, so these typedefs describe the default configuration.
package downstream_pkg;

    localparam int NUM_CLIENTS_DEF = 32;
    localparam int CLIENT_W_DEF    = $clog2(NUM_CLIENTS_DEF);
    localparam int AMT_W_DEF       = 16;
    localparam int ACC_W_DEF       = 24;

    typedef logic [CLIENT_W_DEF-1:0] client_id_t;
    typedef logic [AMT_W_DEF-1:0]    amt_t;
    typedef logic [ACC_W_DEF-1:0]    acc_t;

    // Saturation value of a stored total in the default build.
    localparam acc_t ACC_MAX = '1;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/downstream_acc_ram.sv
// downstream_acc_ram: per-client total storage.
//   One write port, two synchronous read ports:
//     pipe_* : read-first (returns the pre-write value); the accumulator
//              pipeline resolves same-address hazards by forwarding.
//     qry_*  : write-first (a same-cycle write to qry_addr is returned).
// Ports:
//   clk, rst        clock, synchronous active-high reset (query register only)
//   we/waddr/wdata  write port
//   pipe_addr/data  pipeline read, 1-cycle latency
//   qry_addr/data   query read, 1-cycle latency, resets to 0
module downstream_acc_ram #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] pipe_addr,
    output logic [DW-1:0] pipe_data,
    input  logic [AW-1:0] qry_addr,
    output logic [DW-1:0] qry_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        pipe_data <= mem[pipe_addr];
    end

    always_ff @(posedge clk) begin
        if (rst)
            qry_data <= '0;
        else if (we && (waddr == qry_addr))
            qry_data <= wdata;
        else
            qry_data <= mem[qry_addr];
    end

endmodule

// File: rtl/downstream_cxl_accumulator.sv
// downstream_cxl_accumulator: per-client running total of cancelled amounts.
//   After reset a sweep writes 0 to every entry (busy_init high), then events
//   are accepted on a valid/ready handshake and accumulated with a two-stage
//   read-modify-write (S0 read, S1 add/saturate/write) at one event per cycle.
//   A same-client write in S1 is forwarded into the following S0 read.
//   clr_valid zeroes one client in the S1 slot of the next cycle.
// Optional feature (macro DOWNSTREAM_CXL_EVENT_COUNT_EN): 32-bit evt_count of
//   committed updates, wrapping.
// Ports:
//   clk, HRESET                 clock, synchronous active-high reset
//   in_valid/ready/client_id/amount  cancel event handshake
//   clr_valid/clr_client_id     clear one client's total
//   rd_client_id/rd_data        query port, 1-cycle latency, write-first
//   upd_valid/client_id/total   pulse per committed update
//   sat_flag                    sticky saturation indicator
//   busy_init                   high during post-reset clear sweep
module downstream_cxl_accumulator
    import downstream_pkg::*;
#(
    parameter int NUM_CLIENTS = 32,
    parameter int CLIENT_W    = $clog2(NUM_CLIENTS),
    parameter int AMT_W       = 16,
    parameter int ACC_W       = 24
) (
    input  logic                clk,
    input  logic                HRESET,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CLIENT_W-1:0] in_client_id,
    input  logic [AMT_W-1:0]    in_amount,
    input  logic                clr_valid,
    input  logic [CLIENT_W-1:0] clr_client_id,
    input  logic [CLIENT_W-1:0] rd_client_id,
    output logic [ACC_W-1:0]    rd_data,
    output logic                upd_valid,
    output logic [CLIENT_W-1:0] upd_client_id,
    output logic [ACC_W-1:0]    upd_total,
    output logic                sat_flag,
`ifdef DOWNSTREAM_CXL_EVENT_COUNT_EN
    output logic [31:0]         evt_count,
`endif
    output logic                busy_init
);

    localparam logic [CLIENT_W-1:0] LAST_ADDR = CLIENT_W'(NUM_CLIENTS - 1);

    acc_state_e          state;
    logic [CLIENT_W-1:0] sweep_cnt;

    // S1 stage registers
    logic                s1_vld;
    logic [CLIENT_W-1:0] s1_client;
    logic [AMT_W-1:0]    s1_amt;
    logic                s1_fwd;
    logic [ACC_W-1:0]    s1_fwd_data;
    logic                clr_s1;
    logic [CLIENT_W-1:0] clr_s1_client;

    logic                we;
    logic [CLIENT_W-1:0] waddr;
    logic [ACC_W-1:0]    wdata;
    logic [ACC_W-1:0]    pipe_q;
    logic [ACC_W-1:0]    old_total;
    logic [ACC_W:0]      sum;
    logic                ovf;
    logic [ACC_W-1:0]    new_total;
    logic                accept;
    logic                commit;

    assign in_ready  = (state == RUN) && !clr_valid;
    assign accept    = in_valid && in_ready;

    // The RAM pipeline port is read-first, so a write landing on the same edge
    // as the S0 read is captured at accept time and substituted here.
    assign old_total = s1_fwd ? s1_fwd_data : pipe_q;
    assign sum       = {1'b0, old_total} + (ACC_W+1)'(s1_amt);
    assign ovf       = sum[ACC_W];
    assign new_total = ovf ? '1 : sum[ACC_W-1:0];

    // A clear in S1 and an update in S1 cannot coincide (clr_valid blocks
    // acceptance in its cycle); if they ever did, the clear takes the port.
    assign commit        = s1_vld && !clr_s1 && !HRESET;
    assign upd_valid     = commit;
    assign upd_client_id = commit ? s1_client : '0;
    assign upd_total     = commit ? new_total : '0;

    always_comb begin
        we    = 1'b0;
        waddr = s1_client;
        wdata = new_total;
        if (HRESET) begin
            we = 1'b0;
        end else if (state == INIT) begin
            we    = 1'b1;
            waddr = sweep_cnt;
            wdata = '0;
        end else if (clr_s1) begin
            we    = 1'b1;
            waddr = clr_s1_client;
            wdata = '0;
        end else if (s1_vld) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (HRESET) begin
            state         <= INIT;
            busy_init     <= 1'b1;
            sweep_cnt     <= '0;
            s1_vld        <= 1'b0;
            s1_client     <= '0;
            s1_amt        <= '0;
            s1_fwd        <= 1'b0;
            s1_fwd_data   <= '0;
            clr_s1        <= 1'b0;
            clr_s1_client <= '0;
            sat_flag      <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    sweep_cnt <= sweep_cnt + 1'b1;
                    if (sweep_cnt == LAST_ADDR) begin
                        state     <= RUN;
                        busy_init <= 1'b0;
                    end
                end
                RUN: ;
                default: state <= INIT;
            endcase
            s1_vld        <= accept;
            s1_client     <= in_client_id;
            s1_amt        <= in_amount;
            s1_fwd        <= we && (waddr == in_client_id);
            s1_fwd_data   <= wdata;
            clr_s1        <= clr_valid && (state == RUN);
            clr_s1_client <= clr_client_id;
            if (commit && ovf)
                sat_flag <= 1'b1;
        end
    end

`ifdef DOWNSTREAM_CXL_EVENT_COUNT_EN
    always_ff @(posedge clk) begin
        if (HRESET)
            evt_count <= '0;
        else if (commit)
            evt_count <= evt_count + 32'd1;
    end
`endif

    downstream_acc_ram #(
        .DEPTH (NUM_CLIENTS),
        .AW    (CLIENT_W),
        .DW    (ACC_W)
    ) u_ram (
        .clk       (clk),
        .rst       (HRESET),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .pipe_addr (in_client_id),
        .pipe_data (pipe_q),
        .qry_addr  (rd_client_id),
        .qry_data  (rd_data)
    );

endmodule

// File: tb/tb_downstream_cxl_accumulator.sv
// Bench for downstream_cxl_accumulator (default parameters).
// A per-client array model is updated at each accepted event / taken clear;
// a negedge process compares handshake, update, saturation and query outputs
// every cycle, and directed sequences pin the model with literal totals.
module tb_downstream_cxl_accumulator;
    import downstream_pkg::*;

    localparam int NC = 32;

    logic        clk = 1'b0;
    logic        HRESET;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_client_id;
    logic [15:0] in_amount;
    logic        clr_valid;
    logic [4:0]  clr_client_id;
    logic [4:0]  rd_client_id;
    logic [23:0] rd_data;
    logic        upd_valid;
    logic [4:0]  upd_client_id;
    logic [23:0] upd_total;
    logic        sat_flag;
    logic        busy_init;
`ifdef DOWNSTREAM_CXL_EVENT_COUNT_EN
    logic [31:0] evt_count;
`endif

    downstream_cxl_accumulator dut (
        .clk           (clk),
        .HRESET        (HRESET),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_client_id  (in_client_id),
        .in_amount     (in_amount),
        .clr_valid     (clr_valid),
        .clr_client_id (clr_client_id),
        .rd_client_id  (rd_client_id),
        .rd_data       (rd_data),
        .upd_valid     (upd_valid),
        .upd_client_id (upd_client_id),
        .upd_total     (upd_total),
        .sat_flag      (sat_flag),
`ifdef DOWNSTREAM_CXL_EVENT_COUNT_EN
        .evt_count     (evt_count),
`endif
        .busy_init     (busy_init)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        int     c;
        longint t;
        bit     ovf;
    } exp_t;

    longint model [NC];
    exp_t   exp_q [$];
    longint upd_log [$];
    int     init_left = -1;   // sweep cycles still to go; -1 before first reset
    bit     exp_sat = 0;
    bit     rd_chk = 0;
    longint exp_rd = 0;
    longint evt_seen = 0;

    always @(posedge clk) begin
        bit pre_busy;
        pre_busy = (init_left != 0);
        rd_chk   = (init_left == 0) && !HRESET;
        exp_rd   = model[rd_client_id];
        if (HRESET) begin
            init_left = NC;
            foreach (model[i]) model[i] = 0;
            exp_q.delete();
            exp_sat  = 0;
            evt_seen = 0;
        end else begin
            if (init_left > 0) init_left--;
            if (!pre_busy && in_valid && !clr_valid) begin
                exp_t e;
                longint s;
                s = model[in_client_id] + longint'(in_amount);
                e.ovf = (s > longint'(ACC_MAX));
                if (e.ovf) s = longint'(ACC_MAX);
                model[in_client_id] = s;
                e.c = int'(in_client_id);
                e.t = s;
                exp_q.push_back(e);
            end
            if (!pre_busy && clr_valid)
                model[clr_client_id] = 0;
        end
    end

    always @(negedge clk) begin
        if (init_left >= 0) begin
            exp_t e;
            bit   expv;
            chk("busy_init", longint'(busy_init), longint'(init_left > 0));
            chk("in_ready", longint'(in_ready), longint'(init_left == 0 && !clr_valid));
            expv = 0;
            e.c = 0; e.t = 0; e.ovf = 0;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                expv = !HRESET;
            end
            chk("upd_valid", longint'(upd_valid), longint'(expv));
            if (expv) begin
                chk("upd_client_id", longint'(upd_client_id), longint'(e.c));
                chk("upd_total", longint'(upd_total), e.t);
                evt_seen++;
            end
            chk("sat_flag", longint'(sat_flag), longint'(exp_sat));
            if (expv && e.ovf) exp_sat = 1;
            if (rd_chk)
                chk("rd_data", longint'(rd_data), exp_rd);
            if (upd_valid) upd_log.push_back(longint'(upd_total));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int c, input int a);
        in_valid     = 1'b1;
        clr_valid    = 1'b0;
        in_client_id = 5'(c);
        in_amount    = 16'(a);
        cyc();
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        clr_valid = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic clr(input int c);
        in_valid      = 1'b0;
        clr_valid     = 1'b1;
        clr_client_id = 5'(c);
        #1;
        chk("in_ready_during_clr", longint'(in_ready), 0);
        cyc();
        clr_valid = 1'b0;
    endtask

    task automatic rd(input int c, input longint exp);
        in_valid     = 1'b0;
        rd_client_id = 5'(c);
        cyc();
        chk($sformatf("rd_client_%0d", c), longint'(rd_data), exp);
    endtask

    task automatic wait_sweep(input string nm);
        int n = 0;
        while (busy_init && n < 100) begin
            cyc();
            n++;
        end
        chk(nm, longint'(n), longint'(NC));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        HRESET = 1'b1; in_valid = 1'b0; in_client_id = '0; in_amount = '0;
        clr_valid = 1'b0; clr_client_id = '0; rd_client_id = '0;
        repeat (3) cyc();
        chk("rst_busy_init", longint'(busy_init), 1);
        chk("rst_in_ready", longint'(in_ready), 0);
        chk("rst_upd_valid", longint'(upd_valid), 0);
        chk("rst_upd_total", longint'(upd_total), 0);
        chk("rst_upd_client", longint'(upd_client_id), 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        chk("rst_rd_data", longint'(rd_data), 0);
        HRESET = 1'b0;
        wait_sweep("init_len");
        for (int i = 0; i < NC; i++) rd(i, 0);

        // back-to-back same client
        upd_log.delete();
        send(3, 100); send(3, 250); idle(2);
        chk("c3_upd_count", longint'(upd_log.size()), 2);
        if (upd_log.size() == 2) begin
            chk("c3_upd0", upd_log[0], 100);
            chk("c3_upd1", upd_log[1], 350);
        end
        rd(3, 350);

        // interleaved clients
        upd_log.delete();
        send(1, 10); send(2, 10); send(1, 10); send(2, 10); idle(2);
        chk("interleave_upd_count", longint'(upd_log.size()), 4);
        rd(1, 20); rd(2, 20);

        // saturation on client 5: 256*0xFFFF + 0xF0 = 0xFFFFF0
        repeat (256) send(5, 16'hFFFF);
        send(5, 16'h00F0); idle(2);
        rd(5, 24'hFFFFF0);
        chk("sat_before", longint'(sat_flag), 0);
        upd_log.delete();
        send(5, 16'h0020); idle(2);
        send(5, 1); idle(2);
        chk("sat_upd_count", longint'(upd_log.size()), 2);
        if (upd_log.size() == 2) begin
            chk("sat_upd0", upd_log[0], 24'hFFFFFF);
            chk("sat_upd1", upd_log[1], 24'hFFFFFF);
        end
        chk("sat_sticky", longint'(sat_flag), 1);
        rd(5, 24'hFFFFFF);

        // clear right after an event on 7, then an event forwarding the 0
        upd_log.delete();
        send(7, 40); clr(7); send(7, 5); idle(2);
        chk("clr_upd_count", longint'(upd_log.size()), 2);
        if (upd_log.size() == 2) begin
            chk("clr_upd0", upd_log[0], 40);
            chk("clr_upd1", upd_log[1], 5);
        end
        rd(7, 5);
        clr(7); rd(7, 0); rd(7, 0);
        chk("sat_still", longint'(sat_flag), 1);

        // reset with events in flight
        upd_log.delete();
        send(9, 11);
        in_valid = 1'b1; in_client_id = 5'd10; in_amount = 16'd22; HRESET = 1'b1;
        #1;
        chk("inflight_dropped", longint'(upd_valid), 0);
        cyc();
        in_valid = 1'b0;
        cyc();
        HRESET = 1'b0;
        repeat (10) cyc();
        HRESET = 1'b1;      // restart mid-sweep
        cyc();
        HRESET = 1'b0;
        wait_sweep("init_len_restart");
        chk("post_rst_upd_count", longint'(upd_log.size()), 0);
        chk("post_rst_sat", longint'(sat_flag), 0);
        for (int i = 0; i < NC; i++) rd(i, 0);
        send(9, 7); idle(2);
        rd(9, 7);
`ifdef DOWNSTREAM_CXL_EVENT_COUNT_EN
        chk("evt_count", longint'(evt_count), evt_seen);
`endif
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
